// File: rtl/ifs_sync_capture.sv
// Parametrised input capture / synchroniser pipeline with clock enable, PD set,
// reset-value and GSR mode, pipeline-fill VALID and registered per-bit edge pulses.
module ifs_sync_capture #(
  parameter int               WIDTH  = 8,
  parameter int               STAGES = 2,
  parameter logic [WIDTH-1:0] INIT   = '0,
  parameter                   GSR    = "ENABLED"
) (
  input  logic             SCLK,
  input  logic             RSTN,
  input  logic             CE,
  input  logic             PD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             VALID
);

  localparam int CW = $clog2(STAGES + 1);
  localparam bit GSR_EN = (GSR == "ENABLED");

  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $fatal(1, "ifs_sync_capture: STAGES must be 1..8");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "ifs_sync_capture: WIDTH must be 1..64");
  end

  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             valid;

  assign valid = (cnt_q == CW'(STAGES));

  always_comb begin
    s_d    = s_q;
    cnt_d  = cnt_q;
    rise_d = '0;
    fall_d = '0;
    if (CE) begin
      s_d[0] = D | {WIDTH{PD}};
      for (int i = 1; i < STAGES; i++) begin
        s_d[i] = s_q[i-1];
      end
      if (!valid) begin
        cnt_d = cnt_q + CW'(1);
      end
      // Edges seen while the pipeline is still filling are not real input activity.
      if (valid) begin
        rise_d = s_d[STAGES-1] & ~s_q[STAGES-1];
        fall_d = ~s_d[STAGES-1] & s_q[STAGES-1];
      end
    end
  end

  always_ff @(posedge SCLK) begin
    if (!RSTN) begin
      cnt_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
    // With GSR disabled the data stages keep running through reset.
    for (int i = 0; i < STAGES; i++) begin
      s_q[i] <= (!RSTN && GSR_EN) ? INIT : s_d[i];
    end
  end

  assign Q     = s_q[STAGES-1];
  assign RISE  = rise_q;
  assign FALL  = fall_q;
  assign VALID = valid;

endmodule
